// File: rtl/game_sequencer_if.sv
// Frame handoff between the game sequencer and the VGA grid drawer.
interface game_sequencer_if;
  logic draw_req;
  logic draw_done;

  modport master (output draw_req, input draw_done);
  modport slave  (input draw_req, output draw_done);
endinterface

// File: rtl/game_sequencer.sv
// Starflux per-frame controller: frame tick, datapath enable sequencing, draw handshake, game over.
// Optional pause input enabled by defining GAME_SEQ_PAUSE_EN.
module game_sequencer #(
  parameter int unsigned FRAME_DIV = 833333,
  parameter int unsigned DIV_W     = 20
) (
  input  logic        clk,
  input  logic        reset,
`ifdef GAME_SEQ_PAUSE_EN
  input  logic        pause,
`endif
  input  logic        start,
  input  logic        hit_ship,
  input  logic        hit_enemy,
  input  logic [3:0]  ship_health,
  game_sequencer_if.master vga,
  output logic        shipUpdateEn,
  output logic        gridUpdateEn,
  output logic        health_update,
  output logic        current_score_update,
  output logic        gameover_signal,
  output logic        game_over,
  output logic [7:0]  overrun,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    SHIP  = 3'd2,
    GRID  = 3'd3,
    CHECK = 3'd4,
    DRAW  = 3'd5,
    OVER  = 3'd6
  } state_t;

  localparam logic [DIV_W-1:0] LAST = DIV_W'(FRAME_DIV - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [7:0]       ovr_d;
  logic             start_q;
  logic             start_rise;
  logic             running;
  logic             hold;
  logic             tick;

`ifdef GAME_SEQ_PAUSE_EN
  assign hold = pause && (state_q == WAIT);
`else
  assign hold = 1'b0;
`endif

  assign start_rise = start & ~start_q;
  assign running    = (state_q == WAIT) || (state_q == SHIP) || (state_q == GRID) ||
                      (state_q == CHECK) || (state_q == DRAW);
  assign tick       = running && !hold && (cnt_q == LAST);

  // The collision results are only meaningful during the CHECK cycle.
  assign health_update        = (state_q == CHECK) && hit_ship;
  assign current_score_update = (state_q == CHECK) && hit_enemy;
  assign state                = state_q;

  // Next-state, frame counter and overrun accounting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovr_d   = overrun;

    if (!running)      cnt_d = '0;
    else if (tick)     cnt_d = '0;
    else if (!hold)    cnt_d = cnt_q + DIV_W'(1);

    // A tick outside WAIT is a dropped frame; no catch-up is scheduled.
    if (tick && (state_q != WAIT) && (overrun != 8'hFF)) ovr_d = overrun + 8'd1;

    case (state_q)
      IDLE:    if (start_rise) state_d = WAIT;
      WAIT:    if (tick) state_d = SHIP;
      SHIP:    state_d = GRID;
      GRID:    state_d = CHECK;
      CHECK:   if ((ship_health == 4'd0) || (hit_ship && (ship_health == 4'd1)))
                 state_d = OVER;
               else
                 state_d = DRAW;
      DRAW:    if (vga.draw_done) state_d = WAIT;
      OVER:    if (start_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with Moore outputs registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      start_q         <= 1'b0;
      overrun         <= 8'd0;
      shipUpdateEn    <= 1'b0;
      gridUpdateEn    <= 1'b0;
      gameover_signal <= 1'b0;
      game_over       <= 1'b0;
      vga.draw_req    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      start_q         <= start;
      overrun         <= ovr_d;
      shipUpdateEn    <= (state_d == SHIP);
      gridUpdateEn    <= (state_d == GRID);
      gameover_signal <= (state_d == OVER) && (state_q != OVER);
      game_over       <= (state_d == OVER);
      vga.draw_req    <= (state_d == DRAW);
    end
  end

endmodule
